ksa32_rr_arbiter: RTL and testbench

//   Shares one koggestone32bit adder among NUM_REQ requesters using round-robin arbitration.

---
 rtl/ksa32_rr_arbiter_if.sv | 31 +++
 rtl/ksa32_rr_arbiter.sv | 164 ++++++++++++++++
 tb/tb_ksa32_rr_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ksa32_rr_arbiter_if.sv
// Request/response bundle between the ALU-side requesters and the shared adder arbiter.
// The arbiter owns the slave modport; requesters and the result consumer sit on master.
interface ksa32_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_last;
  logic [2*NUM_REQ-1:0]  req_op;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_sum;
  logic                  rsp_cout;
  logic                  rsp_ovf;
  logic                  rsp_zero;
  logic                  chain_abort;

  modport master (
    output req_valid, req_last, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf, rsp_zero, chain_abort
  );

  modport slave (
    input  req_valid, req_last, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf, rsp_zero, chain_abort
  );
endinterface

// File: rtl/ksa32_rr_arbiter.sv
// Round-robin arbiter sharing one 32-bit Kogge-Stone adder among NUM_REQ requesters,
// with a grant lock and carry feedback for chained multi-word ADC/SBC sequences.
module ksa32_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LOCK_TO = 16
) (
  input logic              clk,
  input logic              rst,
  ksa32_rr_arbiter_if.slave bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(LOCK_TO + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state_q;
  logic [ID_W-1:0] owner_q;
  logic [ID_W-1:0] rr_ptr_q;
  logic            carry_q;
  logic [CNT_W-1:0] idle_cnt_q;

  logic            rsp_valid_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [31:0]     rsp_sum_q;
  logic            rsp_cout_q;
  logic            rsp_ovf_q;
  logic            rsp_zero_q;

  logic [31:0] a_arr  [NUM_REQ];
  logic [31:0] b_arr  [NUM_REQ];
  logic [1:0]  op_arr [NUM_REQ];

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] cand;
  logic            out_free;
  logic            accept;
  logic            abort;

  logic [1:0]  op_sel;
  logic [31:0] a_sel;
  logic [31:0] b_eff;
  logic        last_sel;
  logic        cin;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  logic [31:0] g_lvl [6];
  logic [31:0] p_lvl [6];

  function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] p);
    return (p == ID_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign a_arr[gi]         = bus.req_a[32*gi +: 32];
      assign b_arr[gi]         = bus.req_b[32*gi +: 32];
      assign op_arr[gi]        = bus.req_op[2*gi +: 2];
      assign bus.req_ready[gi] = accept & (grant_idx == ID_W'(gi)) & ~rst;
    end
  endgenerate

  // While locked only the owner competes; otherwise scan upward from rr_ptr with wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (state_q == LOCKED) begin
      grant_found = bus.req_valid[owner_q];
      grant_idx   = owner_q;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
        if (!grant_found && bus.req_valid[cand]) begin
          grant_found = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  assign out_free = ~rsp_valid_q | bus.rsp_ready;
  assign accept   = grant_found & out_free;
  assign abort    = (state_q == LOCKED) & ~accept & (idle_cnt_q == CNT_W'(LOCK_TO - 1));

  assign op_sel   = op_arr[grant_idx];
  assign a_sel    = a_arr[grant_idx];
  assign b_eff    = op_sel[0] ? ~b_arr[grant_idx] : b_arr[grant_idx];
  assign last_sel = bus.req_last[grant_idx];
  // Stored carry only feeds ADC/SBC inside a chain; outside one they degrade to ADD/SUB.
  assign cin      = (op_sel[1] && state_q == LOCKED) ? carry_q : op_sel[0];

  // Kogge-Stone prefix tree; cin is folded into the bit-0 generate term.
  assign p_lvl[0] = a_sel ^ b_eff;
  assign g_lvl[0] = (a_sel & b_eff) | {31'b0, p_lvl[0][0] & cin};

  genvar gj;
  generate
    for (gj = 0; gj < 5; gj++) begin : g_ks
      localparam int D = 1 << gj;
      assign g_lvl[gj+1] = g_lvl[gj] | (p_lvl[gj] & (g_lvl[gj] << D));
      assign p_lvl[gj+1] = p_lvl[gj] & ((p_lvl[gj] << D) | ((32'd1 << D) - 32'd1));
    end
  endgenerate

  assign sum  = p_lvl[0] ^ {g_lvl[5][30:0], cin};
  assign cout = g_lvl[5][31];
  assign ovf  = (a_sel[31] == b_eff[31]) & (sum[31] != a_sel[31]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      carry_q     <= 1'b0;
      idle_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_zero_q  <= 1'b0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= grant_idx;
      rsp_sum_q   <= sum;
      rsp_cout_q  <= cout;
      rsp_ovf_q   <= ovf;
      rsp_zero_q  <= (sum == 32'd0);
      carry_q     <= cout;
      idle_cnt_q  <= '0;
      if (last_sel) begin
        state_q  <= IDLE;
        rr_ptr_q <= ptr_inc(grant_idx);
      end else begin
        state_q  <= LOCKED;
        owner_q  <= grant_idx;
      end
    end else begin
      if (bus.rsp_ready) rsp_valid_q <= 1'b0;
      if (state_q == LOCKED) begin
        if (abort) begin
          state_q    <= IDLE;
          rr_ptr_q   <= ptr_inc(owner_q);
          carry_q    <= 1'b0;
          idle_cnt_q <= '0;
        end else begin
          idle_cnt_q <= idle_cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_sum     = rsp_sum_q;
  assign bus.rsp_cout    = rsp_cout_q;
  assign bus.rsp_ovf     = rsp_ovf_q;
  assign bus.rsp_zero    = rsp_zero_q;
  assign bus.chain_abort = abort;
endmodule

// File: tb/tb_ksa32_rr_arbiter.sv
// Bench for ksa32_rr_arbiter: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a behavioural arbiter/adder model.
module tb_ksa32_rr_arbiter;
  localparam int N   = 4;
  localparam int LT  = 16;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ksa32_rr_arbiter_if #(.NUM_REQ(N), .ID_W(IDW)) bus ();
  ksa32_rr_arbiter #(.NUM_REQ(N), .LOCK_TO(LT)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Behavioural model state
  bit             m_locked;
  logic [IDW-1:0] m_owner;
  logic [IDW-1:0] m_rr;
  int             m_idle;
  bit             m_carry;
  bit             m_rv;
  logic [IDW-1:0] m_id;
  logic [31:0]    m_sum;
  bit             m_cout, m_ovf, m_zero;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = '0; m_rr = '0; m_idle = 0; m_carry = 0;
    m_rv = 0; m_id = '0; m_sum = '0; m_cout = 0; m_ovf = 0; m_zero = 0;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0; bus.req_last = '0; bus.req_op = '0;
    bus.req_a = '0; bus.req_b = '0;
  endtask

  task automatic set_req(input int i, input bit v, input bit last, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    bus.req_valid[i]      = v;
    bus.req_last[i]       = last;
    bus.req_op[2*i +: 2]  = op;
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
  endtask

  // Called at the falling edge: compare DUT to model, advance model, move to posedge+1.
  task automatic step();
    logic [N-1:0]   er;
    logic [IDW-1:0] g, c;
    bit             found, freeb, acc, ab, cin;
    logic [1:0]     op;
    logic [31:0]    a, b, beff;
    logic [32:0]    full;
    freeb = !m_rv || bus.rsp_ready;
    found = 0; g = '0;
    if (m_locked) begin
      found = bus.req_valid[m_owner]; g = m_owner;
    end else begin
      for (int k = 0; k < N; k++) begin
        c = IDW'((int'(m_rr) + k) % N);
        if (!found && bus.req_valid[c]) begin found = 1; g = c; end
      end
    end
    acc = found && freeb;
    er = '0;
    if (acc) er[g] = 1'b1;
    ab = m_locked && !acc && (m_idle == LT - 1);
    chk("req_ready", 64'(bus.req_ready), 64'(er));
    chk("chain_abort", 64'(bus.chain_abort), 64'(ab));
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_rv));
    if (m_rv) begin
      chk("rsp_id", 64'(bus.rsp_id), 64'(m_id));
      chk("rsp_sum", 64'(bus.rsp_sum), 64'(m_sum));
      chk("rsp_cout", 64'(bus.rsp_cout), 64'(m_cout));
      chk("rsp_ovf", 64'(bus.rsp_ovf), 64'(m_ovf));
      chk("rsp_zero", 64'(bus.rsp_zero), 64'(m_zero));
    end
    if (acc) begin
      op   = bus.req_op[2*g +: 2];
      a    = bus.req_a[32*g +: 32];
      b    = bus.req_b[32*g +: 32];
      beff = op[0] ? ~b : b;
      cin  = (op[1] && m_locked) ? m_carry : op[0];
      full = {1'b0, a} + {1'b0, beff} + 33'(cin);
      m_sum = full[31:0]; m_cout = full[32];
      m_ovf = (a[31] == beff[31]) && (m_sum[31] != a[31]);
      m_zero = (m_sum == 32'd0);
      m_id = g; m_rv = 1; m_carry = m_cout; m_idle = 0;
      if (bus.req_last[g]) begin m_locked = 0; m_rr = IDW'((int'(g) + 1) % N); end
      else begin m_locked = 1; m_owner = g; end
      $display("[TB] cyc %0d accept req%0d op=%0d a=%h b=%h cin=%0d last=%0d -> sum=%h cout=%0d",
               cyc, g, op, a, b, cin, bus.req_last[g], m_sum, m_cout);
    end else begin
      if (bus.rsp_ready) m_rv = 0;
      if (m_locked) begin
        if (ab) begin
          m_locked = 0; m_rr = IDW'((int'(m_owner) + 1) % N); m_carry = 0; m_idle = 0;
          $display("[TB] cyc %0d lock of req%0d timed out", cyc, m_owner);
        end else begin
          m_idle++;
        end
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    bus.rsp_ready = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int aborts, abort_at;
    logic [3:0] rot_exp;
    clear_reqs();
    bus.rsp_ready = 1'b0;
    model_reset();

    // Reset state
    #2;
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_abort", 64'(bus.chain_abort), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Single ADD 5+7 from req0
    set_req(0, 1, 1, 2'b00, 32'd5, 32'd7);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("add_ready", 64'(bus.req_ready), 64'b0001);
    step();
    clear_reqs();
    @(negedge clk);
    chk("add_sum", 64'(bus.rsp_sum), 64'd12);
    chk("add_cout", 64'(bus.rsp_cout), 64'd0);
    chk("add_ovf", 64'(bus.rsp_ovf), 64'd0);
    chk("add_zero", 64'(bus.rsp_zero), 64'd0);
    chk("add_id", 64'(bus.rsp_id), 64'd0);
    chk("add_valid", 64'(bus.rsp_valid), 64'd1);
    step();

    // Round-robin rotation with all requesters valid
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1, 1, 2'b00, 32'(i * 10), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rot_exp = 4'b0001 << (i % 4);
      chk("rotate", 64'(bus.req_ready), 64'(rot_exp));
      step();
    end
    clear_reqs();
    tick();

    // 64-bit add on req2: 0x00000001_FFFFFFFF + 1
    set_req(2, 1, 0, 2'b00, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    chk("w1_ready", 64'(bus.req_ready), 64'b0100);
    step();
    set_req(0, 1, 1, 2'b00, 32'd1, 32'd1);
    set_req(1, 1, 1, 2'b00, 32'd1, 32'd1);
    set_req(3, 1, 1, 2'b00, 32'd1, 32'd1);
    set_req(2, 1, 1, 2'b10, 32'd1, 32'd0);
    @(negedge clk);
    chk("w2_ready", 64'(bus.req_ready), 64'b0100);
    chk("w1_sum", 64'(bus.rsp_sum), 64'd0);
    chk("w1_cout", 64'(bus.rsp_cout), 64'd1);
    chk("w1_zero", 64'(bus.rsp_zero), 64'd1);
    step();
    clear_reqs();
    @(negedge clk);
    chk("w2_sum", 64'(bus.rsp_sum), 64'd2);
    chk("w2_cout", 64'(bus.rsp_cout), 64'd0);
    step();

    // Subtract edge cases
    set_req(3, 1, 1, 2'b01, 32'h8000_0000, 32'd1);
    tick();
    set_req(3, 1, 1, 2'b01, 32'd3, 32'd5);
    @(negedge clk);
    chk("sub1_sum", 64'(bus.rsp_sum), 64'h7FFF_FFFF);
    chk("sub1_ovf", 64'(bus.rsp_ovf), 64'd1);
    chk("sub1_cout", 64'(bus.rsp_cout), 64'd1);
    step();
    clear_reqs();
    @(negedge clk);
    chk("sub2_sum", 64'(bus.rsp_sum), 64'hFFFF_FFFE);
    chk("sub2_cout", 64'(bus.rsp_cout), 64'd0);
    step();

    // Lock timeout: req1 opens a chain with carry out, then goes silent
    set_req(1, 1, 0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    clear_reqs();
    set_req(2, 1, 1, 2'b10, 32'd5, 32'd6);
    aborts = 0; abort_at = -1;
    for (int i = 0; i < LT; i++) begin
      @(negedge clk);
      if (bus.chain_abort) begin aborts++; abort_at = i; end
      chk("to_blocked", 64'(bus.req_ready), 64'd0);
      step();
    end
    chk("to_abort_count", 64'(aborts), 64'd1);
    chk("to_abort_cycle", 64'(abort_at), 64'(LT - 1));
    @(negedge clk);
    chk("to_req2_ready", 64'(bus.req_ready), 64'b0100);
    step();
    clear_reqs();
    @(negedge clk);
    chk("to_adc_sum", 64'(bus.rsp_sum), 64'd11);
    step();

    // Output hold under back-pressure
    set_req(0, 1, 1, 2'b00, 32'd100, 32'd1);
    tick();
    bus.rsp_ready = 1'b0;
    set_req(0, 1, 1, 2'b00, 32'd200, 32'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_ready", 64'(bus.req_ready), 64'd0);
      chk("hold_sum", 64'(bus.rsp_sum), 64'd101);
      step();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("release_ready", 64'(bus.req_ready), 64'b0001);
    step();
    clear_reqs();
    @(negedge clk);
    chk("release_sum", 64'(bus.rsp_sum), 64'd202);
    step();

    // Reset in the middle of a chain
    set_req(0, 1, 0, 2'b00, 32'd1, 32'd1);
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rst_sum", 64'(bus.rsp_sum), 64'd0);
    chk("mid_rst_ready", 64'(bus.req_ready), 64'd0);
    chk("mid_rst_abort", 64'(bus.chain_abort), 64'd0);
    model_reset();
    clear_reqs();
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(1, 1, 1, 2'b00, 32'd4, 32'd4);
    @(negedge clk);
    chk("post_rst_ready", 64'(bus.req_ready), 64'b0010);
    step();

    // Random traffic with varying request density
    for (int c = 0; c < 600; c++) begin
      int dens;
      logic [31:0] av, bv;
      dens = ((c / 100) % 3 == 0) ? 4 : 2;
      for (int i = 0; i < N; i++) begin
        av = ($urandom % 4 == 0) ? 32'hFFFF_FFFF : $urandom;
        bv = ($urandom % 5 == 0) ? 32'h8000_0000 : $urandom;
        set_req(i, ($urandom % dens) == 0, ($urandom % 4) != 0, 2'($urandom % 4), av, bv);
      end
      bus.rsp_ready = ($urandom % 4) != 0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
